// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM pipeline buffer bundle: EX-side input bundle, MEM-side head payload,
// flush, handshakes and the derived branch/jump/forwarding/perf outputs.
// master = the EX/MEM environment driving inputs; slave = the buffer itself.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int M_W     = 3,
  parameter int WB_W    = 2,
  parameter int JSHF_W  = 28,
  parameter int CNT_W   = 16
);
  // EX side
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [M_W-1:0]     in_M;
  logic [WB_W-1:0]    in_WB;
  logic [DATA_W-1:0]  in_add;
  logic               in_flag;
  logic [DATA_W-1:0]  in_res;
  logic [DATA_W-1:0]  in_dat2;
  logic [RADDR_W-1:0] in_mux;
  logic [JSHF_W-1:0]  in_ShfJ;
  logic               J_in;
  // MEM side
  logic               out_valid;
  logic               out_ready;
  logic [M_W-1:0]     ou_M;
  logic [WB_W-1:0]    ou_WB;
  logic [DATA_W-1:0]  ou_add;
  logic               ou_flag;
  logic [DATA_W-1:0]  ou_res;
  logic [DATA_W-1:0]  ou_dat2;
  logic [RADDR_W-1:0] ou_mux;
  logic [JSHF_W-1:0]  ou_ShfJ;
  logic               J_out;
  // derived status
  logic               branch_taken;
  logic               jump_taken;
  logic               fwd_en;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output flush, in_valid, in_M, in_WB, in_add, in_flag, in_res, in_dat2,
           in_mux, in_ShfJ, J_in, out_ready,
    input  in_ready, out_valid, ou_M, ou_WB, ou_add, ou_flag, ou_res, ou_dat2,
           ou_mux, ou_ShfJ, J_out, branch_taken, jump_taken, fwd_en, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_M, in_WB, in_add, in_flag, in_res, in_dat2,
           in_mux, in_ShfJ, J_in, out_ready,
    output in_ready, out_valid, ou_M, ou_WB, ou_add, ou_flag, ou_res, ou_dat2,
           ou_mux, ou_ShfJ, J_out, branch_taken, jump_taken, fwd_en, stall_cnt
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// Purpose: EX/MEM pipeline buffer with 2-entry skid (main + skid), flush, fwd/branch/jump status, stall counter.
// Latency: 1 cycle from accept to out_valid when empty; 1 bundle/cycle sustained.
// Backpressure: in_ready = !skid_valid straight from a flop; no combinational path from out_ready.
// Ports: clk, rst (async, active-high); bus (slave modport) carries flush, the EX-side
// in_* bundle with in_valid/in_ready, the MEM-side ou_* head with out_valid/out_ready,
// and branch_taken / jump_taken / fwd_en / stall_cnt.
module ex_mem_pipe_reg #(
  parameter int DATA_W       = 32,
  parameter int RADDR_W      = 5,
  parameter int M_W          = 3,
  parameter int WB_W         = 2,
  parameter int JSHF_W       = 28,
  parameter int BRANCH_BIT   = 2,
  parameter int REGWRITE_BIT = 1,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  ex_mem_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic [M_W-1:0]     m;
    logic [WB_W-1:0]    wb;
    logic [DATA_W-1:0]  add;
    logic               flag;
    logic [DATA_W-1:0]  res;
    logic [DATA_W-1:0]  dat2;
    logic [RADDR_W-1:0] mux;
    logic [JSHF_W-1:0]  shfj;
    logic               j;
  } bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bundle_t          main_q, skid_q, in_b;
  logic             main_vld, skid_vld;
  logic             accept, drain;
  logic [CNT_W-1:0] stall_q;

  assign in_b.m    = bus.in_M;
  assign in_b.wb   = bus.in_WB;
  assign in_b.add  = bus.in_add;
  assign in_b.flag = bus.in_flag;
  assign in_b.res  = bus.in_res;
  assign in_b.dat2 = bus.in_dat2;
  assign in_b.mux  = bus.in_mux;
  assign in_b.shfj = bus.in_ShfJ;
  assign in_b.j    = bus.J_in;

  assign bus.in_ready = ~skid_vld;
  assign accept       = bus.in_valid & ~skid_vld;
  assign drain        = main_vld & bus.out_ready;

  // Flush kills only the control fields; data fields keep their last value.
  function automatic bundle_t kill_ctl(input bundle_t b);
    bundle_t r;
    r   = b;
    r.m = '0;
    r.wb = '0;
    r.j = 1'b0;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (bus.flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= kill_ctl(main_q);
      skid_q   <= kill_ctl(skid_q);
    end else if (!main_vld || drain) begin
      // Main frees up: the older skid entry always goes first to keep order.
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        if (accept) begin
          skid_q   <= in_b;
          skid_vld <= 1'b1;
        end else begin
          skid_vld <= 1'b0;
        end
      end else begin
        skid_vld <= 1'b0;
        if (accept) begin
          main_q   <= in_b;
          main_vld <= 1'b1;
        end else begin
          main_vld <= 1'b0;
        end
      end
    end else if (accept) begin
      // Main is stalled: park the input; in_ready drops next cycle.
      skid_q   <= in_b;
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_vld && !bus.out_ready && stall_q != CNT_MAX) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.out_valid = main_vld;
  assign bus.ou_M      = main_vld ? main_q.m  : '0;
  assign bus.ou_WB     = main_vld ? main_q.wb : '0;
  assign bus.J_out     = main_vld & main_q.j;
  assign bus.ou_add    = main_q.add;
  assign bus.ou_flag   = main_q.flag;
  assign bus.ou_res    = main_q.res;
  assign bus.ou_dat2   = main_q.dat2;
  assign bus.ou_mux    = main_q.mux;
  assign bus.ou_ShfJ   = main_q.shfj;
  assign bus.stall_cnt = stall_q;

  assign bus.branch_taken = main_vld & main_q.m[BRANCH_BIT] & main_q.flag;
  assign bus.jump_taken   = main_vld & main_q.j;
  assign bus.fwd_en       = main_vld & main_q.wb[REGWRITE_BIT] & (main_q.mux != '0);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: queue-based reference model checked every negedge,
// plus directed sequences with literal expectations.
module tb_ex_mem_pipe_reg;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  typedef struct packed {
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] add;
    logic        flag;
    logic [31:0] res;
    logic [31:0] dat2;
    logic [4:0]  mux;
    logic [27:0] shfj;
    logic        j;
  } bnd_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   chk_en;

  ex_mem_pipe_reg_if #(.CNT_W(CNT_W)) bus ();

  ex_mem_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bnd_t q[$];
  bnd_t last_head;
  int   m_cnt;
  bit   m_acc, m_drn;

  function automatic bnd_t cur_in();
    bnd_t b;
    b.m = bus.in_M; b.wb = bus.in_WB; b.add = bus.in_add; b.flag = bus.in_flag;
    b.res = bus.in_res; b.dat2 = bus.in_dat2; b.mux = bus.in_mux;
    b.shfj = bus.in_ShfJ; b.j = bus.J_in;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      last_head = '0;
      m_cnt = 0;
    end else begin
      m_acc = bus.in_valid && (q.size() < 2);
      m_drn = (q.size() > 0) && bus.out_ready;
      if (q.size() > 0 && !bus.out_ready && m_cnt < CMAX) m_cnt++;
      if (bus.flush) begin
        q.delete();
        last_head.m = '0; last_head.wb = '0; last_head.j = 1'b0;
      end else begin
        if (m_drn) void'(q.pop_front());
        if (m_acc) q.push_back(cur_in());
        if (q.size() > 0) last_head = q[0];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit   hv;
      bnd_t h;
      hv = q.size() > 0;
      h  = last_head;
      chk("out_valid", bus.out_valid, hv);
      chk("in_ready", bus.in_ready, q.size() < 2);
      chk("ou_M", bus.ou_M, hv ? h.m : 3'd0);
      chk("ou_WB", bus.ou_WB, hv ? h.wb : 2'd0);
      chk("J_out", bus.J_out, hv && h.j);
      chk("ou_add", bus.ou_add, h.add);
      chk("ou_flag", bus.ou_flag, h.flag);
      chk("ou_res", bus.ou_res, h.res);
      chk("ou_dat2", bus.ou_dat2, h.dat2);
      chk("ou_mux", bus.ou_mux, h.mux);
      chk("ou_ShfJ", bus.ou_ShfJ, h.shfj);
      chk("branch_taken", bus.branch_taken, hv && h.m[2] && h.flag);
      chk("jump_taken", bus.jump_taken, hv && h.j);
      chk("fwd_en", bus.fwd_en, hv && h.wb[1] && (h.mux != 0));
      chk("stall_cnt", bus.stall_cnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [1:0] wb,
                       input logic [31:0] add, input logic fl, input logic [31:0] res,
                       input logic [4:0] mx, input logic j);
    bus.in_valid = v;
    bus.in_M     = m;
    bus.in_WB    = wb;
    bus.in_add   = add;
    bus.in_flag  = fl;
    bus.in_res   = res;
    bus.in_dat2  = res ^ 32'hFFFF_0000;
    bus.in_mux   = mx;
    bus.in_ShfJ  = {res[15:0], 12'h5A5};
    bus.J_in     = j;
  endtask

  task automatic data(input logic v, input logic [31:0] res);
    drive(v, 3'b001, 2'b01, res + 32'h100, 1'b0, res, 5'd3, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    data(1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_stall", bus.stall_cnt, 0);
    chk("rst_res", bus.ou_res, 0);

    // 1: streaming with out_ready=1
    data(1, 32'd1); tick();
    chk("t1_valid", bus.out_valid, 1); chk("t1_res1", bus.ou_res, 1);
    data(1, 32'd2); tick();
    chk("t1_res2", bus.ou_res, 2); chk("t1_rdy", bus.in_ready, 1);
    data(1, 32'd3); tick();
    chk("t1_res3", bus.ou_res, 3);
    data(0, 32'd0); tick();
    chk("t1_empty", bus.out_valid, 0);

    // 2: stall fills main + skid, then drain in order
    bus.out_ready = 1'b0;
    data(1, 32'hA); tick();
    data(1, 32'hB); tick();
    chk("t2_rdy_low", bus.in_ready, 0);
    data(1, 32'hC); tick();
    chk("t2_head_A", bus.ou_res, 32'hA); chk("t2_still_low", bus.in_ready, 0);
    bus.out_ready = 1'b1; tick();
    chk("t2_head_B", bus.ou_res, 32'hB); chk("t2_rdy_back", bus.in_ready, 1);
    tick();
    chk("t2_head_C", bus.ou_res, 32'hC);
    data(0, 32'd0); tick();
    chk("t2_done", bus.out_valid, 0);

    // 3: flush with both entries full and input valid
    bus.out_ready = 1'b0;
    drive(1, 3'b111, 2'b11, 32'h0, 1'b1, 32'h11, 5'd9, 1'b1); tick();
    drive(1, 3'b111, 2'b11, 32'h0, 1'b1, 32'h22, 5'd9, 1'b1); tick();
    drive(1, 3'b111, 2'b11, 32'h0, 1'b1, 32'h33, 5'd9, 1'b1);
    bus.flush = 1'b1; tick();
    chk("t3_valid", bus.out_valid, 0); chk("t3_rdy", bus.in_ready, 1);
    chk("t3_M", bus.ou_M, 0); chk("t3_WB", bus.ou_WB, 0);
    drive(1, 3'b111, 2'b11, 32'h0, 1'b1, 32'h44, 5'd9, 1'b1); tick();
    chk("t3_drop_in", bus.out_valid, 0);
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    data(0, 32'd0); tick(); tick();
    chk("t3_no_ghost", bus.out_valid, 0);

    // 4: branch / jump
    drive(1, 3'b100, 2'b00, 32'h40, 1'b1, 32'h7, 5'd0, 1'b0); tick();
    chk("t4_br", bus.branch_taken, 1); chk("t4_add", bus.ou_add, 32'h40);
    drive(1, 3'b100, 2'b00, 32'h40, 1'b0, 32'h7, 5'd0, 1'b0); tick();
    chk("t4_br_nf", bus.branch_taken, 0);
    drive(1, 3'b000, 2'b00, 32'h0, 1'b0, 32'h7, 5'd0, 1'b1); tick();
    chk("t4_jmp", bus.jump_taken, 1);

    // 5: forwarding enable
    drive(1, 3'b000, 2'b10, 32'h0, 1'b0, 32'h9, 5'd0, 1'b0); tick();
    chk("t5_mux0", bus.fwd_en, 0);
    drive(1, 3'b000, 2'b10, 32'h0, 1'b0, 32'h9, 5'd8, 1'b0); tick();
    chk("t5_mux8", bus.fwd_en, 1);
    drive(1, 3'b000, 2'b00, 32'h0, 1'b0, 32'h9, 5'd8, 1'b0); tick();
    chk("t5_nowr", bus.fwd_en, 0);
    data(0, 32'd0); tick();

    // 6: stall counter saturation, then async reset mid-cycle
    bus.out_ready = 1'b0;
    data(1, 32'h66); tick();
    data(1, 32'h77);
    repeat (20) tick();
    chk("t6_sat", bus.stall_cnt, 15);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_rdy", bus.in_ready, 1);
    chk("t6_rst_cnt", bus.stall_cnt, 0);
    chk("t6_rst_res", bus.ou_res, 0);
    chk("t6_rst_add", bus.ou_add, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    data(1, 32'h55); tick();
    chk("t6_after", bus.ou_res, 32'h55);
    data(0, 32'd0); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
